// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for the systolic-array core: steps tile addresses, issues read/engine/write starts
// and overlaps write-back of tile k with tile k+1. Define SA_SCHED_WGT_PRELOAD_EN for weight preload.
module sa_tile_scheduler #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TILE_CNT_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [ADDR_WIDTH-1:0]     i_src_addr,
    input  logic [ADDR_WIDTH-1:0]     i_wgt_addr,
    input  logic [ADDR_WIDTH-1:0]     i_dst_addr,
    input  logic [31:0]               i_tile_bytes,
    input  logic [31:0]               i_wgt_bytes,
    input  logic [TILE_CNT_WIDTH-1:0] i_num_tiles,
    output logic                      o_rd_start,
    output logic [ADDR_WIDTH-1:0]     o_rd_addr,
    output logic [31:0]               o_rd_len,
    input  logic                      i_rd_done,
    input  logic                      i_rd_err,
    output logic                      o_eng_start,
    input  logic                      i_eng_done,
    input  logic                      i_eng_err,
    output logic                      o_wr_start,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr,
    output logic [31:0]               o_wr_len,
    input  logic                      i_wr_done,
    input  logic                      i_wr_err,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [TILE_CNT_WIDTH-1:0] o_tile_idx,
    output logic                      o_buf_sel
);

`ifdef SA_SCHED_WGT_PRELOAD_EN
    typedef enum logic [2:0] {S_IDLE, S_WGT, S_ISSUE, S_WAIT, S_DRAIN, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_ERR} state_t;

    logic unused_wgt;
    assign unused_wgt = ^{i_wgt_addr, i_wgt_bytes};
`endif

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0]     src_acc;
    logic [ADDR_WIDTH-1:0]     dst_acc;
    logic [31:0]               tile_bytes_q;
    logic [TILE_CNT_WIDTH-1:0] num_tiles_q;
    logic                      rd_pend, eng_pend, wr_pend;

    logic rd_ok, eng_ok, wr_ok, any_err, tile_ready, last_tile;
    logic accept, issue_wgt, issue_tile, launch_wr, advance, done_d, err_d;

    // A unit counts as settled once its done pulse or error level is seen; used to drain S_ERR.
    assign rd_ok      = !rd_pend  || i_rd_done  || i_rd_err;
    assign eng_ok     = !eng_pend || i_eng_done || i_eng_err;
    assign wr_ok      = !wr_pend  || i_wr_done  || i_wr_err;
    assign any_err    = i_rd_err || i_eng_err || i_wr_err;
    assign tile_ready = (!rd_pend || i_rd_done) && (!eng_pend || i_eng_done) &&
                        (!wr_pend || i_wr_done);
    assign last_tile  = (o_tile_idx == num_tiles_q - TILE_CNT_WIDTH'(1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        issue_wgt  = 1'b0;
        issue_tile = 1'b0;
        launch_wr  = 1'b0;
        advance    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (state != S_IDLE && i_abort) begin
            state_d = S_IDLE;
        end else if (state != S_IDLE && state != S_ERR && any_err) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        accept = 1'b1;
                        if (i_tile_bytes == '0) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else if (i_num_tiles == '0) begin
                            done_d = 1'b1;
                        end else begin
`ifdef SA_SCHED_WGT_PRELOAD_EN
                            issue_wgt = 1'b1;
                            state_d   = S_WGT;
`else
                            issue_tile = 1'b1;
                            state_d    = S_WAIT;
`endif
                        end
                    end
                end
`ifdef SA_SCHED_WGT_PRELOAD_EN
                S_WGT: begin
                    if (i_rd_done) begin
                        issue_tile = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
`endif
                S_ISSUE: begin
                    issue_tile = 1'b1;
                    state_d    = S_WAIT;
                end
                // The write start goes out first; the next tile's starts follow one cycle later.
                S_WAIT: begin
                    if (tile_ready) begin
                        launch_wr = 1'b1;
                        if (last_tile) begin
                            state_d = S_DRAIN;
                        end else begin
                            advance = 1'b1;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_wr_done) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_ERR: begin
                    if (rd_ok && eng_ok && wr_ok) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            o_rd_start   <= 1'b0;
            o_rd_addr    <= '0;
            o_rd_len     <= '0;
            o_eng_start  <= 1'b0;
            o_wr_start   <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_len     <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_tile_idx   <= '0;
            o_buf_sel    <= 1'b0;
            src_acc      <= '0;
            dst_acc      <= '0;
            tile_bytes_q <= '0;
            num_tiles_q  <= '0;
            rd_pend      <= 1'b0;
            eng_pend     <= 1'b0;
            wr_pend      <= 1'b0;
        end else begin
            o_rd_start  <= issue_wgt || issue_tile;
            o_eng_start <= issue_tile;
            o_wr_start  <= launch_wr;
            o_done      <= done_d;
            o_busy      <= (state_d != S_IDLE);

            if (err_d) begin
                o_error <= 1'b1;
            end else if (accept) begin
                o_error <= 1'b0;
            end

            if (accept) begin
                src_acc      <= i_src_addr;
                dst_acc      <= i_dst_addr;
                tile_bytes_q <= i_tile_bytes;
                num_tiles_q  <= i_num_tiles;
                o_tile_idx   <= '0;
                o_buf_sel    <= 1'b0;
            end

            if (issue_wgt) begin
                o_rd_addr <= i_wgt_addr;
                o_rd_len  <= i_wgt_bytes;
            end else if (issue_tile) begin
                o_rd_addr <= accept ? i_src_addr : src_acc;
                o_rd_len  <= accept ? i_tile_bytes : tile_bytes_q;
            end

            if (launch_wr) begin
                o_wr_addr <= dst_acc;
                o_wr_len  <= tile_bytes_q;
                dst_acc   <= dst_acc + ADDR_WIDTH'(tile_bytes_q);
            end

            if (advance) begin
                src_acc    <= src_acc + ADDR_WIDTH'(tile_bytes_q);
                o_tile_idx <= o_tile_idx + TILE_CNT_WIDTH'(1);
                o_buf_sel  <= ~o_buf_sel;
            end

            // Pending bookkeeping is dropped whenever the job ends, including abort.
            if (state_d == S_IDLE) begin
                rd_pend  <= 1'b0;
                eng_pend <= 1'b0;
                wr_pend  <= 1'b0;
            end else begin
                if (issue_wgt || issue_tile) begin
                    rd_pend <= 1'b1;
                end else if (i_rd_done || i_rd_err) begin
                    rd_pend <= 1'b0;
                end
                if (issue_tile) begin
                    eng_pend <= 1'b1;
                end else if (i_eng_done || i_eng_err) begin
                    eng_pend <= 1'b0;
                end
                if (launch_wr) begin
                    wr_pend <= 1'b1;
                end else if (i_wr_done || i_wr_err) begin
                    wr_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboard bench for sa_tile_scheduler: directed jobs queue expected start/done pulses with their
// cycle, and a negedge monitor pops and compares. Follows SA_SCHED_WGT_PRELOAD_EN when defined.
module tb_sa_tile_scheduler;

    typedef struct {
        int          at;
        logic [31:0] addr;
        logic [31:0] len;
        logic [15:0] idx;
        logic        bsel;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_src_addr = '0;
    logic [31:0] i_wgt_addr = '0;
    logic [31:0] i_dst_addr = '0;
    logic [31:0] i_tile_bytes = '0;
    logic [31:0] i_wgt_bytes = '0;
    logic [15:0] i_num_tiles = '0;
    logic        i_rd_done = 1'b0, i_rd_err = 1'b0;
    logic        i_eng_done = 1'b0, i_eng_err = 1'b0;
    logic        i_wr_done = 1'b0, i_wr_err = 1'b0;
    logic        o_rd_start, o_eng_start, o_wr_start;
    logic [31:0] o_rd_addr, o_rd_len, o_wr_addr, o_wr_len;
    logic        o_busy, o_done, o_error, o_buf_sel;
    logic [15:0] o_tile_idx;

    exp_t rd_q[$];
    exp_t eng_q[$];
    exp_t wr_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic wr_open = 1'b0;

    sa_tile_scheduler dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .i_start(i_start), .i_abort(i_abort),
        .i_src_addr(i_src_addr), .i_wgt_addr(i_wgt_addr), .i_dst_addr(i_dst_addr),
        .i_tile_bytes(i_tile_bytes), .i_wgt_bytes(i_wgt_bytes), .i_num_tiles(i_num_tiles),
        .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
        .i_rd_done(i_rd_done), .i_rd_err(i_rd_err),
        .o_eng_start(o_eng_start), .i_eng_done(i_eng_done), .i_eng_err(i_eng_err),
        .o_wr_start(o_wr_start), .o_wr_addr(o_wr_addr), .o_wr_len(o_wr_len),
        .i_wr_done(i_wr_done), .i_wr_err(i_wr_err),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_tile_idx(o_tile_idx), .o_buf_sel(o_buf_sel)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    function automatic void push_rd(input int at, input logic [31:0] addr, len,
                                    input logic [15:0] idx, input logic bsel);
        exp_t e;
        e.at = at; e.addr = addr; e.len = len; e.idx = idx; e.bsel = bsel;
        rd_q.push_back(e);
    endfunction

    function automatic void push_tile(input int at, input logic [31:0] addr, len,
                                      input logic [15:0] idx, input logic bsel);
        exp_t e;
        push_rd(at, addr, len, idx, bsel);
        e.at = at; e.addr = '0; e.len = '0; e.idx = idx; e.bsel = bsel;
        eng_q.push_back(e);
    endfunction

    function automatic void push_wr(input int at, input logic [31:0] addr, len);
        exp_t e;
        e.at = at; e.addr = addr; e.len = len; e.idx = '0; e.bsel = 1'b0;
        wr_q.push_back(e);
    endfunction

    task automatic done_pulse(input logic rd, eng, wr);
        i_rd_done = rd; i_eng_done = eng; i_wr_done = wr;
        tick(1);
        i_rd_done = 1'b0; i_eng_done = 1'b0; i_wr_done = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] src, wgt, dst, tb, wb, input logic [15:0] nt);
        i_src_addr = src; i_wgt_addr = wgt; i_dst_addr = dst;
        i_tile_bytes = tb; i_wgt_bytes = wb; i_num_tiles = nt;
        i_start = 1'b1;
        if (tb != 0) begin
            if (nt == 0) begin
                done_q.push_back(cyc + 1);
            end else begin
`ifdef SA_SCHED_WGT_PRELOAD_EN
                push_rd(cyc + 1, wgt, wb, 16'd0, 1'b0);
`else
                push_tile(cyc + 1, src, tb, 16'd0, 1'b0);
`endif
            end
        end
        tick(1);
        i_start = 1'b0;
    endtask

    // With preload built in, the weight read must complete before tile 0 starts.
    task automatic finish_wgt(input logic [31:0] src, tb);
`ifdef SA_SCHED_WGT_PRELOAD_EN
        tick(2);
        push_tile(cyc + 1, src, tb, 16'd0, 1'b0);
        done_pulse(1'b1, 1'b0, 1'b0);
`else
        if (src === 32'hx && tb === 32'hx) tick(1);
`endif
    endtask

    always @(negedge ACLK) begin
        exp_t e;
        if (ARESETN) begin
            if (o_rd_start) begin
                checkOutput("rd_start_expected", 64'(rd_q.size() > 0), 64'd1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    checkOutput("rd_cycle", 64'(cyc), 64'(e.at));
                    checkOutput("rd_addr", o_rd_addr, e.addr);
                    checkOutput("rd_len", o_rd_len, e.len);
                    checkOutput("rd_tile_idx", o_tile_idx, e.idx);
                    checkOutput("rd_buf_sel", o_buf_sel, e.bsel);
                end
            end
            if (o_eng_start) begin
                checkOutput("eng_start_expected", 64'(eng_q.size() > 0), 64'd1);
                if (eng_q.size() > 0) begin
                    e = eng_q.pop_front();
                    checkOutput("eng_cycle", 64'(cyc), 64'(e.at));
                    checkOutput("eng_tile_idx", o_tile_idx, e.idx);
                end
            end
            if (o_wr_start) begin
                checkOutput("wr_start_expected", 64'(wr_q.size() > 0), 64'd1);
                checkOutput("wr_single_outstanding", 64'(wr_open), 64'd0);
                wr_open = 1'b1;
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    checkOutput("wr_cycle", 64'(cyc), 64'(e.at));
                    checkOutput("wr_addr", o_wr_addr, e.addr);
                    checkOutput("wr_len", o_wr_len, e.len);
                end
            end else if (i_wr_done) begin
                wr_open = 1'b0;
            end
            if (o_done) begin
                checkOutput("done_expected", 64'(done_q.size() > 0), 64'd1);
                if (done_q.size() > 0) begin
                    checkOutput("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] reset");
        tick(3);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_starts", {o_rd_start, o_eng_start, o_wr_start, o_done}, 0);
        checkOutput("reset_error", o_error, 0);
        checkOutput("reset_addrs", {o_rd_addr, o_wr_addr}, 0);
        checkOutput("reset_idx_buf", {o_tile_idx, o_buf_sel}, 0);
        ARESETN = 1'b1;
        tick(2);

        $display("[TB] three-tile job with overlapping write-back");
        applyStimulus(32'h1000, 32'h8000, 32'h2000, 32'h100, 32'h40, 16'd3);
        checkOutput("busy_after_start", o_busy, 1);
        finish_wgt(32'h1000, 32'h100);
        tick(2);
        push_wr(cyc + 1, 32'h2000, 32'h100);
        push_tile(cyc + 2, 32'h1100, 32'h100, 16'd1, 1'b1);
        done_pulse(1'b1, 1'b1, 1'b0);
        tick(1);
        done_pulse(1'b0, 1'b0, 1'b1);
        done_pulse(1'b0, 1'b1, 1'b0);
        tick(1);
        push_wr(cyc + 1, 32'h2100, 32'h100);
        push_tile(cyc + 2, 32'h1200, 32'h100, 16'd2, 1'b0);
        done_pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        done_pulse(1'b1, 1'b1, 1'b0);
        tick(20);
        checkOutput("busy_while_wr_held", o_busy, 1);
        push_wr(cyc + 1, 32'h2200, 32'h100);
        done_pulse(1'b0, 1'b0, 1'b1);
        tick(3);
        done_q.push_back(cyc + 1);
        done_pulse(1'b0, 1'b0, 1'b1);
        checkOutput("busy_after_done", o_busy, 0);
        checkOutput("error_after_job", o_error, 0);
        tick(3);

        $display("[TB] empty job");
        applyStimulus(32'h3000, 32'h8000, 32'h3800, 32'h100, 32'h40, 16'd0);
        checkOutput("empty_job_busy", o_busy, 0);
        tick(3);

        $display("[TB] zero tile size");
        applyStimulus(32'h3000, 32'h8000, 32'h3800, 32'h0, 32'h40, 16'd5);
        checkOutput("zero_size_error", o_error, 1);
        tick(2);
        checkOutput("zero_size_busy_release", o_busy, 0);
        checkOutput("zero_size_error_sticky", o_error, 1);
        tick(2);

        $display("[TB] engine error during tile 1 of 4");
        applyStimulus(32'h4000, 32'h9000, 32'h5000, 32'h80, 32'h20, 16'd4);
        checkOutput("start_clears_error", o_error, 0);
        finish_wgt(32'h4000, 32'h80);
        tick(2);
        push_wr(cyc + 1, 32'h5000, 32'h80);
        push_tile(cyc + 2, 32'h4080, 32'h80, 16'd1, 1'b1);
        done_pulse(1'b1, 1'b1, 1'b0);
        tick(2);
        i_eng_err = 1'b1;
        tick(1);
        i_eng_err = 1'b0;
        checkOutput("eng_err_sets_error", o_error, 1);
        checkOutput("err_busy_while_pending", o_busy, 1);
        done_pulse(1'b1, 1'b0, 1'b0);
        checkOutput("err_busy_wr_pending", o_busy, 1);
        done_pulse(1'b0, 1'b0, 1'b1);
        checkOutput("err_busy_released", o_busy, 0);
        checkOutput("err_sticky", o_error, 1);
        tick(3);

        $display("[TB] abort while waiting on the engine");
        applyStimulus(32'h6000, 32'h9000, 32'h7000, 32'h40, 32'h20, 16'd2);
        checkOutput("restart_clears_error", o_error, 0);
        finish_wgt(32'h6000, 32'h40);
        tick(2);
        done_pulse(1'b1, 1'b0, 1'b0);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_error_unchanged", o_error, 0);
        tick(4);

        $display("[TB] address wrap with ignored mid-job start");
        applyStimulus(32'hFFFF_FF80, 32'h0, 32'hFFFF_FF80, 32'h80, 32'h10, 16'd2);
        finish_wgt(32'hFFFF_FF80, 32'h80);
        tick(1);
        i_src_addr = 32'hDEAD_0000; i_dst_addr = 32'hBEEF_0000; i_num_tiles = 16'd9;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        push_wr(cyc + 1, 32'hFFFF_FF80, 32'h80);
        push_tile(cyc + 2, 32'h0000_0000, 32'h80, 16'd1, 1'b1);
        done_pulse(1'b1, 1'b1, 1'b0);
        tick(1);
        done_pulse(1'b0, 1'b0, 1'b1);
        done_pulse(1'b0, 1'b1, 1'b0);
        push_wr(cyc + 1, 32'h0000_0000, 32'h80);
        done_pulse(1'b1, 1'b0, 1'b0);
        tick(2);
        done_q.push_back(cyc + 1);
        done_pulse(1'b0, 1'b0, 1'b1);
        checkOutput("wrap_job_busy", o_busy, 0);
        tick(5);

        checkOutput("rd_queue_drained", 64'(rd_q.size()), 0);
        checkOutput("eng_queue_drained", 64'(eng_q.size()), 0);
        checkOutput("wr_queue_drained", 64'(wr_q.size()), 0);
        checkOutput("done_queue_drained", 64'(done_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
